display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit 7-segment stopwatch display. It takes the four BCD digits produced by the stopwatch datapath (min_l, min_r, sec_l, sec_r) and drives one shared active-low segment bus and four active-low anodes, one digit per time slot. It inserts a ghosting dead-time at the start of each slot and supports per-digit blink and leading-zero blanking. It sits between the count/BCD split logic and the board pins.

---
 rtl/display_scan_ctrl_if.sv | 22 ++
 rtl/display_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Bus between the stopwatch datapath/board pins and the display scan controller.
interface display_scan_ctrl_if;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic        lz_blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    // Datapath / board side: drives digits and controls, observes the pins.
    modport master (
        output en, digits, blink_mask, lz_blank,
        input  seg, an, frame_done
    );

    // Scan controller side.
    modport slave (
        input  en, digits, blink_mask, lz_blank,
        output seg, an, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with dead-time,
// per-digit blink, leading-zero blanking and frame-coherent digit snapshot.
module display_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 16,
    parameter int unsigned BLINK_DIV = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave bus
);

    localparam int unsigned PRE_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;
    localparam logic [3:0]       AN_OFF   = 4'b1111;

    logic [PRE_W-1:0] r_pre;
    logic [1:0]       r_idx;
    logic [BLK_W-1:0] r_blk_cnt;
    logic             r_blk_phase;
    logic [15:0]      r_snap;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_frame_done;

    logic [PRE_W-1:0] w_pre_nxt;
    logic [1:0]       w_idx_nxt;
    logic [BLK_W-1:0] w_blk_cnt_nxt;
    logic             w_blk_phase_nxt;
    logic [3:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;
    logic             w_frame_done_nxt;
    logic             w_snap_load;
    logic [15:0]      w_snap_eff;
    logic [3:0]       w_digit;
    logic [3:0]       w_lz_supp;
    logic [3:0]       w_supp;
    logic             w_pre_last;
    logic             w_frame_end;
    logic             w_dead;

    // 7-segment decode, g..a active low; non-BCD codes render dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Dead-time window at the start of each slot (absent when BLANK_CYC is 0).
    if (BLANK_CYC == 0) begin : g_no_dead
        assign w_dead = 1'b0;
    end else begin : g_dead
        assign w_dead = (r_pre < PRE_W'(BLANK_CYC));
    end

    // Next-state and next-output computation for the scan counters and pins.
    always_comb begin
        w_pre_nxt        = r_pre;
        w_idx_nxt        = r_idx;
        w_blk_cnt_nxt    = r_blk_cnt;
        w_blk_phase_nxt  = r_blk_phase;
        w_an_nxt         = AN_OFF;
        w_seg_nxt        = SEG_OFF;
        w_frame_done_nxt = 1'b0;

        w_pre_last  = (r_pre == PRE_LAST);
        w_frame_end = bus.en && w_pre_last && (r_idx == 2'd3);
        w_snap_load = bus.en && (r_pre == '0) && (r_idx == 2'd0);
        // Decode from the value being captured this cycle so a zero dead-time still shows the new frame.
        w_snap_eff  = w_snap_load ? bus.digits : r_snap;
        w_digit     = w_snap_eff[{r_idx, 2'b00} +: 4];

        w_lz_supp = 4'b0000;
        if (bus.lz_blank) begin
            w_lz_supp[3] = (w_snap_eff[15:12] == 4'd0);
            w_lz_supp[2] = (w_snap_eff[15:8]  == 8'd0);
        end
        w_supp = w_lz_supp | ({4{r_blk_phase}} & bus.blink_mask);

        if (bus.en) begin
            if (w_pre_last) begin
                w_pre_nxt = '0;
                w_idx_nxt = r_idx + 2'd1;
            end else begin
                w_pre_nxt = r_pre + PRE_W'(1);
            end

            if (w_frame_end) begin
                w_frame_done_nxt = 1'b1;
                if (r_blk_cnt == BLK_LAST) begin
                    w_blk_cnt_nxt   = '0;
                    w_blk_phase_nxt = ~r_blk_phase;
                end else begin
                    w_blk_cnt_nxt = r_blk_cnt + BLK_W'(1);
                end
            end

            if (!w_dead && !w_supp[r_idx]) begin
                w_an_nxt  = ~(4'b0001 << r_idx);
                w_seg_nxt = seg_decode(w_digit);
            end
        end
    end

    // State, snapshot and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre        <= '0;
            r_idx        <= 2'd0;
            r_blk_cnt    <= '0;
            r_blk_phase  <= 1'b0;
            r_snap       <= 16'h0000;
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_pre        <= w_pre_nxt;
            r_idx        <= w_idx_nxt;
            r_blk_cnt    <= w_blk_cnt_nxt;
            r_blk_phase  <= w_blk_phase_nxt;
            if (w_snap_load) begin
                r_snap <= bus.digits;
            end
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a short scan (8 cycles/slot, 2 dead, blink every 2 frames).
module tb_display_scan_ctrl;

    localparam int unsigned SCAN_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned BLINK_DIV = 2;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] SOFF = 7'b1111111;
    localparam logic [3:0] AN0  = 4'b1110;
    localparam logic [3:0] AN1  = 4'b1101;
    localparam logic [3:0] AN2  = 4'b1011;
    localparam logic [3:0] AN3  = 4'b0111;
    localparam logic [3:0] AOFF = 4'b1111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    display_scan_ctrl_if u_if ();

    display_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .BLINK_DIV (BLINK_DIV)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    // One rising edge, then compare all outputs on the following falling edge.
    task automatic run_cycle(input logic [3:0] ea, input logic [6:0] es, input logic efd, input string tag);
        @(posedge clk);
        @(negedge clk);
        total++;
        if (u_if.an !== ea) begin
            bad++;
            $display("FAIL %s an: got %b want %b", tag, u_if.an, ea);
        end
        total++;
        if (u_if.seg !== es) begin
            bad++;
            $display("FAIL %s seg: got %b want %b", tag, u_if.seg, es);
        end
        total++;
        if (u_if.frame_done !== efd) begin
            bad++;
            $display("FAIL %s frame_done: got %b want %b", tag, u_if.frame_done, efd);
        end
    endtask

    // Eight cycles of one slot: two dark dead-time cycles, then six with the given an/seg.
    task automatic check_slot(input logic [3:0] ea, input logic [6:0] es, input logic last, input string tag);
        for (int p = 0; p < 8; p++) begin
            run_cycle((p < 2) ? AOFF : ea, (p < 2) ? SOFF : es, last && (p == 7),
                      $sformatf("%s p%0d", tag, p));
        end
    endtask

    // Full frame; slot s uses ea[4s+:4] and es[7s+:7].
    task automatic check_frame(input logic [15:0] ea, input logic [27:0] es, input string tag);
        for (int s = 0; s < 4; s++) begin
            check_slot(ea[4*s +: 4], es[7*s +: 7], s == 3, $sformatf("%s s%0d", tag, s));
        end
    endtask

    // Reset with given inputs; release lands just after a falling edge.
    task automatic do_reset(input logic [15:0] d, input logic [3:0] mask, input logic lz);
        @(negedge clk);
        rst_n             = 1'b0;
        u_if.en           = 1'b1;
        u_if.digits       = d;
        u_if.blink_mask   = mask;
        u_if.lz_blank     = lz;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        u_if.en         = 1'b1;
        u_if.digits     = 16'h1234;
        u_if.blink_mask = 4'b0000;
        u_if.lz_blank   = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (u_if.an !== AOFF) begin
            bad++;
            $display("FAIL reset an: got %b want %b", u_if.an, AOFF);
        end
        total++;
        if (u_if.seg !== SOFF) begin
            bad++;
            $display("FAIL reset seg: got %b want %b", u_if.seg, SOFF);
        end
        total++;
        if (u_if.frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset frame_done: got %b want 0", u_if.frame_done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        check_frame({AN3, AN2, AN1, AN0}, {S1, S2, S3, S4}, "scan f0");
        check_frame({AN3, AN2, AN1, AN0}, {S1, S2, S3, S4}, "scan f1");
    endtask

    task automatic test_snapshot();
        check_slot(AN0, S4, 1'b0, "snap s0");
        u_if.digits = 16'h5678;
        check_slot(AN1, S3, 1'b0, "snap s1");
        check_slot(AN2, S2, 1'b0, "snap s2");
        check_slot(AN3, S1, 1'b1, "snap s3");
        check_frame({AN3, AN2, AN1, AN0}, {S5, S6, S7, S8}, "snap next");
    endtask

    task automatic test_lz_blank();
        do_reset(16'h0005, 4'b0000, 1'b1);
        check_frame({AOFF, AOFF, AN1, AN0}, {SOFF, SOFF, S0, S5}, "lz 0005");
        u_if.digits = 16'h0105;
        check_frame({AOFF, AN2, AN1, AN0}, {SOFF, S1, S0, S5}, "lz 0105");
    endtask

    task automatic test_blink();
        do_reset(16'h1234, 4'b0011, 1'b0);
        for (int f = 0; f < 6; f++) begin
            if (f == 2 || f == 3) begin
                check_frame({AN3, AN2, AOFF, AOFF}, {S1, S2, SOFF, SOFF}, $sformatf("blink f%0d", f));
            end else begin
                check_frame({AN3, AN2, AN1, AN0}, {S1, S2, S3, S4}, $sformatf("blink f%0d", f));
            end
        end
    endtask

    task automatic test_enable_hold();
        do_reset(16'h1234, 4'b0000, 1'b0);
        check_slot(AN0, S4, 1'b0, "en s0");
        check_slot(AN1, S3, 1'b0, "en s1");
        for (int p = 0; p < 5; p++) begin
            run_cycle((p < 2) ? AOFF : AN2, (p < 2) ? SOFF : S2, 1'b0, $sformatf("en pre p%0d", p));
        end
        u_if.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            run_cycle(AOFF, SOFF, 1'b0, $sformatf("en off k%0d", k));
        end
        u_if.en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_cycle(AN2, S2, 1'b0, $sformatf("en resume k%0d", k));
        end
        check_slot(AN3, S1, 1'b1, "en s3");
        check_frame({AN3, AN2, AN1, AN0}, {S1, S2, S3, S4}, "en next");
    endtask

    task automatic test_bad_code_async_reset();
        do_reset(16'hA000, 4'b0000, 1'b0);
        check_frame({AN3, AN2, AN1, AN0}, {SOFF, S0, S0, S0}, "code A");
        check_slot(AN0, S0, 1'b0, "ar s0");
        for (int p = 0; p < 4; p++) begin
            run_cycle((p < 2) ? AOFF : AN1, (p < 2) ? SOFF : S0, 1'b0, $sformatf("ar s1 p%0d", p));
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (u_if.an !== AOFF) begin
            bad++;
            $display("FAIL async reset an: got %b want %b", u_if.an, AOFF);
        end
        total++;
        if (u_if.seg !== SOFF) begin
            bad++;
            $display("FAIL async reset seg: got %b want %b", u_if.seg, SOFF);
        end
        total++;
        if (u_if.frame_done !== 1'b0) begin
            bad++;
            $display("FAIL async reset frame_done: got %b want 0", u_if.frame_done);
        end
        u_if.digits = 16'h1234;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_frame({AN3, AN2, AN1, AN0}, {S1, S2, S3, S4}, "after ar");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_lz_blank();
        test_blink();
        test_enable_hold();
        test_bad_code_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
